// File: rtl/rr_arbiter83_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   state_t  : arbiter FSM encoding (IDLE / GRANT)
//   N_REQ    : number of requesters
//   IDX_W    : width of a requester index
//   rr_pick  : one-hot round-robin selection starting at a pointer
package rr_arbiter83_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate the request vector right by ptr so the pointer position lands at
  // bit 0, keep only the lowest set bit, then rotate that bit back left by
  // ptr. The doubled vector makes both rotations plain shifts.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   low;
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    low = rot & (~rot + N_REQ'(1));
    dbl = {low, low} << ptr;
    return dbl[2*N_REQ-1:N_REQ];
  endfunction

endpackage

// File: rtl/rr_arbiter83_if.sv
// Request/grant bundle between requesters and the arbiter.
//   en        : arbiter enable
//   req       : request vector, bit i = requester i
//   rel       : current owner gives up the grant ("release" is a reserved word)
//   gnt       : registered one-hot grant, 0 when idle
//   gnt_idx   : binary index of gnt, 0 when gnt = 0
//   gnt_valid : high while gnt != 0
//   timeout   : one-cycle pulse when a grant is revoked by the hold timer
// master = requester side, slave = arbiter side.
interface rr_arbiter83_if;
  import rr_arbiter83_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic             rel;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output en, req, rel,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req, rel,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter83_enc.sv
// 8-to-3 binary encoder (module binary_encoder83).
//   En : enable; q is forced to 0 when low
//   d  : one-hot (or zero) input vector
//   q  : binary index of the set bit of d
// Each output bit is the OR of the input bits whose index has that bit set,
// which is exact for one-hot or zero inputs.
module binary_encoder83 (
  input  logic       En,
  input  logic [7:0] d,
  output logic [2:0] q
);
  localparam logic [7:0] BIT_MASK [3] = '{8'hAA, 8'hCC, 8'hF0};

  for (genvar gi = 0; gi < 3; gi++) begin : g_bit
    assign q[gi] = En & (|(d & BIT_MASK[gi]));
  end
endmodule

// File: rtl/rr_arbiter83.sv
// Round-robin arbiter sharing one resource among 8 requesters.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rr_arbiter83_if.slave (en, req, rel in; gnt, gnt_idx, gnt_valid,
//         timeout out)
// Parameters: TIMEOUT = max hold cycles (0 disables, else 2..255),
//             CW = hold counter width (2^CW > TIMEOUT).
// A grant is issued from IDLE one cycle after a request is sampled and held
// until the owner releases, drops its request, En falls, or the hold timer
// expires. The pointer moves past the owner only when its grant ends.
module rr_arbiter83
  import rr_arbiter83_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter83_if.slave bus
);

  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             timeout_q, timeout_d;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;

  // Early end reasons take precedence over the timer, which is why the
  // timeout pulse is only raised when none of them is present.
  logic early_end;
  logic timer_end;

  assign gnt_valid = (state_q == GRANT);
  assign early_end = bus.rel | ~(|(bus.req & gnt_q)) | ~bus.en;
  assign timer_end = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (bus.en && (|bus.req)) begin
          gnt_d   = rr_pick(bus.req, ptr_q);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (early_end || timer_end) begin
          gnt_d     = '0;
          cnt_d     = '0;
          ptr_d     = gnt_idx + IDX_W'(1);
          timeout_d = ~early_end;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  // The grant register feeds the encoder, so it only ever sees one-hot or 0.
  binary_encoder83 u_enc (
    .En (gnt_valid),
    .d  (gnt_q),
    .q  (gnt_idx)
  );

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx;
  assign bus.gnt_valid = gnt_valid;
  assign bus.timeout   = timeout_q;

endmodule
